ip_vector_loader: RTL and testbench

IP_VECTOR_LOADER -- requirements
Module: ip_vector_loader

---
 rtl/ip_vector_loader.sv | 73 +++++++
 tb/tb_ip_vector_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ip_vector_loader.sv
// ip_vector_loader: packs WIDTH fp32 words into one vector tagged with a rolling ID.
// Define IP_LOADER_ZERO_PAD_EN to let in_last end a short, zero-padded vector.
module ip_vector_loader #(
  parameter int         WIDTH    = 8,
  parameter logic [7:0] ID_START = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data [WIDTH-1:0],
  output logic [7:0]  out_id,
  output logic        out_valid
);
  localparam int LW = $clog2(WIDTH);
  typedef enum logic {FILL, EMIT} state_t;
  state_t        state_q;
  logic [LW-1:0] lane_q;
  logic [31:0]   stage_q [WIDTH-1:0];
  logic [31:0]   stage_d [WIDTH-1:0];
  logic [31:0]   data_q  [WIDTH-1:0];
  logic [7:0]    id_q, oid_q;
  logic          valid_q, accept, done_d;
  assign accept    = in_valid && state_q == FILL;
  assign in_ready  = state_q == FILL;
  assign out_data  = data_q;
  assign out_id    = oid_q;
  assign out_valid = valid_q;
`ifndef IP_LOADER_ZERO_PAD_EN
  logic unused_last;
  assign unused_last = in_last;
`endif
  always_comb begin
    stage_d = stage_q;
    done_d  = accept && lane_q == LW'(WIDTH-1);
    if (accept) stage_d[lane_q] = in_data;
`ifdef IP_LOADER_ZERO_PAD_EN
    if (accept && in_last) begin
      done_d = 1'b1;
      for (int j = 0; j < WIDTH; j++) if (LW'(j) > lane_q) stage_d[j] = '0;
    end
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      lane_q  <= '0;
      stage_q <= '{default: '0};
      data_q  <= '{default: '0};
      id_q    <= ID_START;
      oid_q   <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      stage_q <= stage_d;
      if (state_q == FILL) begin
        if (accept) begin
          state_q <= done_d ? EMIT : FILL;
          lane_q  <= done_d ? '0 : lane_q + 1'b1;
        end
      end else begin
        data_q  <= stage_q;
        oid_q   <= id_q;
        id_q    <= id_q + 8'd1;
        valid_q <= 1'b1;
        lane_q  <= '0;
        state_q <= FILL;
      end
    end
  end
endmodule

// File: tb/tb_ip_vector_loader.sv
// tb_ip_vector_loader: directed bench for ip_vector_loader at WIDTH=8, ID_START=0.
module tb_ip_vector_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] out_data [7:0];
  logic [7:0]  out_id;
  logic        out_valid;
  int          checks = 0;
  int          errors = 0;
  int          npulse = 0;
  int          unstable = 0;
  logic [7:0]  ids [$];
  logic [31:0] prev [8];
  logic [31:0] vec1 [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  ip_vector_loader #(.WIDTH(8), .ID_START(8'h00)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_id(out_id), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (out_valid) begin
      npulse++;
      ids.push_back(out_id);
    end else
      for (int i = 0; i < 8; i++) if (out_data[i] !== prev[i]) unstable++;
    for (int i = 0; i < 8; i++) prev[i] = out_data[i];
  end
  task automatic do_reset;
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  // present one word at a negedge; returns at the negedge after the accepting edge
  task automatic push(input logic [31:0] d, input logic l);
    int t = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $display("FAIL push_timeout in_ready=%b required=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_id !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl ready=%b valid=%b id=%h required 1 0 00", in_ready, out_valid, out_id);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_data[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_data lane%0d got=%h required=00000000", i, out_data[i]);
      end
    end
  endtask
  task automatic test_full;
    do_reset();
    for (int i = 0; i < 8; i++) push(vec1[i], 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_emit ready=%b valid=%b required 0 0", in_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_id !== 8'h00) begin
      errors++;
      $display("FAIL full_pulse valid=%b ready=%b id=%h required 1 1 00", out_valid, in_ready, out_id);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_data[i] !== vec1[i]) begin
        errors++;
        $display("FAIL full_data lane%0d got=%h required=%h", i, out_data[i], vec1[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_one_cycle valid=%b required=0", out_valid);
    end
  endtask
  task automatic test_gaps;
    int base;
    do_reset();
    base = npulse;
    for (int i = 0; i < 8; i++) begin
      push(vec1[i], 1'b0);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (npulse - base !== 1 || out_id !== 8'h00) begin
      errors++;
      $display("FAIL gaps_pulses count=%0d id=%h required 1 00", npulse - base, out_id);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_data[i] !== vec1[i]) begin
        errors++;
        $display("FAIL gaps_data lane%0d got=%h required=%h", i, out_data[i], vec1[i]);
      end
    end
  endtask
  task automatic test_id_wrap;
    do_reset();
    ids.delete();
    unstable = 0;
    for (int v = 0; v < 257; v++)
      for (int l = 0; l < 8; l++) push((32'(v) << 8) | 32'(l), 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (ids.size() !== 257) begin
      errors++;
      $display("FAIL wrap_count got=%0d required=257", ids.size());
    end
    for (int i = 0; i < ids.size(); i++) begin
      checks++;
      if (ids[i] !== 8'(i)) begin
        errors++;
        $display("FAIL wrap_id idx%0d got=%h required=%h", i, ids[i], 8'(i));
      end
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL wrap_stable changes=%0d required=0", unstable);
    end
    checks++;
    if (out_data[5] !== 32'h00010005) begin
      errors++;
      $display("FAIL wrap_last_data got=%h required=00010005", out_data[5]);
    end
  endtask
  task automatic test_midfill_reset;
    int base;
    do_reset();
    for (int i = 0; i < 8; i++) push(vec1[i], 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) push(vec1[i], 1'b0);
    base = npulse;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_data[0] !== 32'h0 || out_data[7] !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midfill_async d0=%h d7=%h ready=%b required 0 0 1", out_data[0], out_data[7], in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h40000000, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (npulse - base !== 1 || out_id !== 8'h00) begin
      errors++;
      $display("FAIL midfill_pulse count=%0d id=%h required 1 00", npulse - base, out_id);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_data[i] !== 32'h40000000) begin
        errors++;
        $display("FAIL midfill_data lane%0d got=%h required=40000000", i, out_data[i]);
      end
    end
  endtask
  task automatic test_short;
    int base;
    logic [31:0] exp [8];
    do_reset();
    base = npulse;
    push(32'h3F800000, 1'b0);
    push(32'h3F800000, 1'b0);
    push(32'h3F800000, 1'b1);
`ifdef IP_LOADER_ZERO_PAD_EN
    for (int i = 0; i < 8; i++) exp[i] = i < 3 ? 32'h3F800000 : 32'h0;
    @(negedge clk);
`else
    for (int i = 0; i < 8; i++) exp[i] = i < 3 ? 32'h3F800000 : 32'h40400000;
    repeat (4) @(negedge clk);
    checks++;
    if (npulse !== base) begin
      errors++;
      $display("FAIL short_nopulse count=%0d required=0", npulse - base);
    end
    for (int i = 0; i < 5; i++) push(32'h40400000, 1'b0);
    @(negedge clk);
`endif
    checks++;
    if (out_valid !== 1'b1 || out_id !== 8'h00) begin
      errors++;
      $display("FAIL short_pulse valid=%b id=%h required 1 00", out_valid, out_id);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_data[i] !== exp[i]) begin
        errors++;
        $display("FAIL short_data lane%0d got=%h required=%h", i, out_data[i], exp[i]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_full();
    test_gaps();
    test_id_wrap();
    test_midfill_reset();
    test_short();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
